// File: rtl/regfile_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_arb_pkg
// Description : Shared types and default widths for the register-file write
//               port arbiter (request struct, grant encoding).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_arb_pkg;

    localparam int unsigned c_data_w_dflt       = 32;
    localparam int unsigned c_addr_w_dflt       = 5;
    localparam int unsigned c_starve_limit_dflt = 4;

    // One register-file write at the default widths.
    typedef struct packed {
        logic [c_addr_w_dflt-1:0] addr;
        logic [c_data_w_dflt-1:0] data;
    } wr_req_t;

    // Which source owns the write port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_LLU  = 2'd2,
        GNT_DBG  = 2'd3
    } gnt_e;

endpackage : regfile_arb_pkg
`default_nettype wire

// File: rtl/regfile_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter_if
// Description : Bundle of the three writer channels (WB, LLU, DBG), the
//               stall request, and the register-file write port.
//               slave  : arbiter side (sources in, RF port out)
//               master : source/environment side
// Ports       : none (signals only)
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wr_arbiter_if
    import regfile_arb_pkg::*;
#(
    parameter int unsigned DATA_W = c_data_w_dflt,
    parameter int unsigned ADDR_W = c_addr_w_dflt
) ();

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              llu_valid;
    logic [ADDR_W-1:0] llu_addr;
    logic [DATA_W-1:0] llu_data;
    logic              llu_ready;

    logic              dbg_valid;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_ready;

    logic              stall_req;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              busy;

    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  llu_valid, llu_addr, llu_data,
        input  dbg_valid, dbg_addr, dbg_data,
        output llu_ready, dbg_ready, stall_req,
        output rf_we, rf_waddr, rf_wdata, busy
    );

    modport master (
        output wb_valid, wb_addr, wb_data,
        output llu_valid, llu_addr, llu_data,
        output dbg_valid, dbg_addr, dbg_data,
        input  llu_ready, dbg_ready, stall_req,
        input  rf_we, rf_waddr, rf_wdata, busy
    );

endinterface : regfile_wr_arbiter_if
`default_nettype wire

// File: rtl/regfile_wr_arbiter_wr_hold_buf.sv
`default_nettype none
// ============================================================================
// Module      : wr_hold_buf
// Description : One-entry valid/ready holding buffer for a deferred register
//               write. Ready only while empty, so peak rate is one write every
//               two cycles. The entry is released by i_pop.
// Ports       : clk, rst (sync, active-low)
//               i_valid/i_addr/i_data/o_ready : upstream handshake
//               i_pop                         : entry granted this cycle
//               o_full/o_addr/o_data          : held entry
// Revision    : 1.0 - initial release
// ============================================================================
module wr_hold_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_valid,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [DATA_W-1:0] i_data,
    output      logic              o_ready,
    input  wire logic              i_pop,
    output      logic              o_full,
    output      logic [ADDR_W-1:0] o_addr,
    output      logic [DATA_W-1:0] o_data
);

    logic              r_full;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_accept;

    // Ready is suppressed during reset so nothing is accepted into a buffer
    // that is being cleared.
    assign o_ready  = ~r_full & rst;
    assign w_accept = i_valid & o_ready;

    // Pop requires a full entry and accept requires an empty one, so the two
    // are mutually exclusive.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_full <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_full <= 1'b1;
            r_addr <= i_addr;
            r_data <= i_data;
        end
    end

    assign o_full = r_full;
    assign o_addr = r_addr;
    assign o_data = r_data;

endmodule : wr_hold_buf
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Shares the register file's single write port between the
//               writeback stage (fixed priority), a long-latency unit and the
//               debug port (both buffered, round-robin). A starvation counter
//               requests a pipeline stall so buffered writes always drain.
// Ports       : clk        sole clock
//               rst        synchronous, active-low reset
//               bus        regfile_wr_arbiter_if.slave (writer channels,
//                          stall_req, busy, registered RF write port)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned DATA_W       = c_data_w_dflt,
    parameter int unsigned ADDR_W       = c_addr_w_dflt,
    parameter int unsigned STARVE_LIMIT = c_starve_limit_dflt
) (
    input  wire logic            clk,
    input  wire logic            rst,
    regfile_wr_arbiter_if.slave  bus
);

    localparam int unsigned        c_cnt_w     = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_limit = c_cnt_w'(STARVE_LIMIT);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    logic              w_llu_full, w_dbg_full;
    logic [ADDR_W-1:0] w_llu_addr, w_dbg_addr;
    logic [DATA_W-1:0] w_llu_data, w_dbg_data;
    logic              w_llu_pop, w_dbg_pop;

    gnt_e              w_gnt;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_data;
    logic              w_any_full;
    logic              w_buf_gnt;

    logic              r_rr_llu;       // 1: LLU wins the next two-way contest
    logic [c_cnt_w-1:0] r_starve_cnt;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;

    // ------------------------------------------------------------------
    // Holding buffers
    // ------------------------------------------------------------------
    wr_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_llu_buf (
        .clk     (clk),
        .rst     (rst),
        .i_valid (bus.llu_valid),
        .i_addr  (bus.llu_addr),
        .i_data  (bus.llu_data),
        .o_ready (bus.llu_ready),
        .i_pop   (w_llu_pop),
        .o_full  (w_llu_full),
        .o_addr  (w_llu_addr),
        .o_data  (w_llu_data)
    );

    wr_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dbg_buf (
        .clk     (clk),
        .rst     (rst),
        .i_valid (bus.dbg_valid),
        .i_addr  (bus.dbg_addr),
        .i_data  (bus.dbg_data),
        .o_ready (bus.dbg_ready),
        .i_pop   (w_dbg_pop),
        .o_full  (w_dbg_full),
        .o_addr  (w_dbg_addr),
        .o_data  (w_dbg_data)
    );

    assign w_any_full = w_llu_full | w_dbg_full;

    // ------------------------------------------------------------------
    // Grant: WB always wins; buffered sources only compete among themselves
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt = GNT_NONE;
        if (bus.wb_valid) begin
            w_gnt = GNT_WB;
        end else if (w_llu_full && w_dbg_full) begin
            w_gnt = r_rr_llu ? GNT_LLU : GNT_DBG;
        end else if (w_llu_full) begin
            w_gnt = GNT_LLU;
        end else if (w_dbg_full) begin
            w_gnt = GNT_DBG;
        end
    end

    always_comb begin
        w_win_addr = bus.wb_addr;
        w_win_data = bus.wb_data;
        case (w_gnt)
            GNT_LLU: begin
                w_win_addr = w_llu_addr;
                w_win_data = w_llu_data;
            end
            GNT_DBG: begin
                w_win_addr = w_dbg_addr;
                w_win_data = w_dbg_data;
            end
            default: begin
                w_win_addr = bus.wb_addr;
                w_win_data = bus.wb_data;
            end
        endcase
    end

    assign w_llu_pop = (w_gnt == GNT_LLU);
    assign w_dbg_pop = (w_gnt == GNT_DBG);
    assign w_buf_gnt = w_llu_pop | w_dbg_pop;

    // ------------------------------------------------------------------
    // Round-robin pointer: moves only when both buffers actually contended
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_llu <= 1'b1;
        end else if (!bus.wb_valid && w_llu_full && w_dbg_full) begin
            r_rr_llu <= ~r_rr_llu;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts WB wins over a waiting buffered write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (w_buf_gnt || !w_any_full) begin
            r_starve_cnt <= '0;
        end else if ((w_gnt == GNT_WB) && (r_starve_cnt != c_cnt_limit)) begin
            r_starve_cnt <= r_starve_cnt + c_cnt_one;
        end
    end

    // ------------------------------------------------------------------
    // Registered write port. Writes to x0 still consume their grant but
    // never assert the write enable.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else if (w_gnt != GNT_NONE) begin
            r_rf_we    <= (w_win_addr != '0);
            r_rf_waddr <= w_win_addr;
            r_rf_wdata <= w_win_data;
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

    assign bus.rf_we     = r_rf_we;
    assign bus.rf_waddr  = r_rf_waddr;
    assign bus.rf_wdata  = r_rf_wdata;
    assign bus.stall_req = (r_starve_cnt == c_cnt_limit);
    assign bus.busy      = w_any_full;

endmodule : regfile_wr_arbiter
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wr_arbiter
// Description : Directed self-checking bench. Stimulus pushes expected RF
//               writes (cycle, addr, data) into a scoreboard; a negedge monitor
//               pops and compares every rf_we and flags unexpected or missing
//               writes and stall protocol violations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_valid  = 1'b0;
        bus.llu_valid = 1'b0;
        bus.dbg_valid = 1'b0;
    endtask

    task automatic push_exp(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en) begin
            if (bus.wb_valid && bus.stall_req) begin
                fails++;
                $display("FAIL protocol: wb_valid high while stall_req high (cycle %0d)", cyc);
            end
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                fails++;
                $display("FAIL missing_write: addr %0d data %0h due cycle %0d not seen",
                         sb[0].addr, sb[0].data, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (bus.rf_we) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: got addr %0d data %0h at cycle %0d, expected none",
                             bus.rf_waddr, bus.rf_wdata, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.addr !== bus.rf_waddr || e.data !== bus.rf_wdata) begin
                        fails++;
                        $display("FAIL rf_write: got cyc %0d addr %0d data %0h, expected cyc %0d addr %0d data %0h",
                                 cyc, bus.rf_waddr, bus.rf_wdata, e.cyc, e.addr, e.data);
                    end
                end
            end
        end
    end

    initial begin : stim
        int c0;
        int scyc;

        // ---------------- Reset with all valids high ----------------
        bus.wb_valid  = 1'b1; bus.wb_addr  = 5'd1;  bus.wb_data  = 32'h1;
        bus.llu_valid = 1'b1; bus.llu_addr = 5'd2;  bus.llu_data = 32'h2;
        bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd3;  bus.dbg_data = 32'h3;
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_rf_we",     64'(bus.rf_we),     64'd0);
        chk("rst_rf_waddr",  64'(bus.rf_waddr),  64'd0);
        chk("rst_rf_wdata",  64'(bus.rf_wdata),  64'd0);
        chk("rst_stall",     64'(bus.stall_req), 64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_llu_ready", 64'(bus.llu_ready), 64'd0);
        chk("rst_dbg_ready", 64'(bus.dbg_ready), 64'd0);
        idle();
        rst = 1'b1;
        mon_en = 1'b1;
        #1;
        chk("rel_llu_ready", 64'(bus.llu_ready), 64'd1);
        chk("rel_dbg_ready", 64'(bus.dbg_ready), 64'd1);
        tick();

        // ---------------- WB only ----------------
        c0 = cyc;
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
        push_exp(c0 + 1, 5'd5, 32'hDEADBEEF);
        tick(); idle();
        tick();

        // ---------------- LLU + DBG together ----------------
        c0 = cyc;
        bus.llu_valid = 1'b1; bus.llu_addr = 5'd3; bus.llu_data = 32'h11;
        bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd7; bus.dbg_data = 32'h22;
        push_exp(c0 + 2, 5'd3, 32'h11);
        push_exp(c0 + 3, 5'd7, 32'h22);
        tick(); idle();                                  // c0+1: both held
        chk("rr_llu_ready_n1", 64'(bus.llu_ready), 64'd0);
        chk("rr_dbg_ready_n1", 64'(bus.dbg_ready), 64'd0);
        chk("rr_busy_n1",      64'(bus.busy),      64'd1);
        tick();                                          // c0+2: LLU freed
        chk("rr_llu_ready_n2", 64'(bus.llu_ready), 64'd1);
        chk("rr_dbg_ready_n2", 64'(bus.dbg_ready), 64'd0);
        tick();                                          // c0+3: DBG freed
        chk("rr_dbg_ready_n3", 64'(bus.dbg_ready), 64'd1);
        chk("rr_busy_n3",      64'(bus.busy),      64'd0);
        tick();

        // ---------------- Starvation ----------------
        c0 = cyc;
        scyc = -1;
        bus.wb_valid  = 1'b1; bus.wb_addr  = 5'd1; bus.wb_data  = 32'h1000;
        bus.llu_valid = 1'b1; bus.llu_addr = 5'd9; bus.llu_data = 32'hAB;
        push_exp(c0 + 1, 5'd1, 32'h1000);
        for (int i = 1; i <= 10; i++) begin
            tick();
            bus.llu_valid = 1'b0;
            if (bus.stall_req) begin
                scyc = cyc;
                break;
            end
            bus.wb_addr = 5'(1 + i);
            bus.wb_data = 32'h1000 + 32'(i);
            push_exp(cyc + 1, 5'(1 + i), 32'h1000 + 32'(i));
        end
        bus.wb_valid = 1'b0;
        chk("starve_stall_cycle", 64'(scyc - c0), 64'd5);
        push_exp(c0 + 6, 5'd9, 32'hAB);
        tick();                                          // c0+6
        chk("starve_stall_clear", 64'(bus.stall_req), 64'd0);
        chk("starve_busy_clear",  64'(bus.busy),      64'd0);
        tick();

        // ---------------- x0 write ----------------
        c0 = cyc;
        bus.llu_valid = 1'b1; bus.llu_addr = 5'd0; bus.llu_data = 32'h55;
        tick(); idle();
        chk("x0_llu_ready_held", 64'(bus.llu_ready), 64'd0);
        tick();
        chk("x0_llu_ready_back", 64'(bus.llu_ready), 64'd1);
        chk("x0_busy",           64'(bus.busy),      64'd0);
        tick(); tick();

        // ---------------- Mid-operation reset ----------------
        bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd8; bus.dbg_data = 32'h77;
        tick(); idle();
        chk("mid_busy_before", 64'(bus.busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_dbg_ready_in_rst", 64'(bus.dbg_ready), 64'd0);
        tick();
        rst = 1'b1;
        chk("mid_busy_after",  64'(bus.busy),     64'd0);
        chk("mid_rf_we_after", 64'(bus.rf_we),    64'd0);
        chk("mid_waddr_after", 64'(bus.rf_waddr), 64'd0);
        tick(); tick(); tick();

        // ---------------- WB + both buffers full (RR fresh from reset) ------
        c0 = cyc;
        bus.llu_valid = 1'b1; bus.llu_addr = 5'd4; bus.llu_data = 32'h44;
        bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd6; bus.dbg_data = 32'h66;
        tick();                                          // c0+1
        bus.llu_valid = 1'b0; bus.dbg_valid = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd2; bus.wb_data = 32'h2222;
        push_exp(c0 + 2, 5'd2, 32'h2222);
        tick(); idle();                                  // c0+2
        push_exp(c0 + 3, 5'd4, 32'h44);
        push_exp(c0 + 4, 5'd6, 32'h66);
        chk("both_stall_low", 64'(bus.stall_req), 64'd0);
        tick(); tick(); tick();

        // ---------------- Drain and summary ----------------
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_regfile_wr_arbiter
`default_nettype wire
